// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared FSM encoding, address/idle constants and BCD helper for the RTC bus responder
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT_DATA,
    ST_WRITE,
    ST_READ
  } state_e;

  localparam logic [7:0] DEF_ADDR_SEC  = 8'h00;
  localparam logic [7:0] DEF_ADDR_MIN  = 8'h01;
  localparam logic [7:0] DEF_ADDR_HOUR = 8'h02;

  localparam logic       IDLE_CS  = 1'b1;
  localparam logic       IDLE_A_D = 1'b0;
  localparam logic       IDLE_WR  = 1'b1;
  localparam logic       IDLE_RD  = 1'b1;
  localparam logic [7:0] IDLE_AD  = 8'h00;

  localparam logic [7:0] BCD_MAX_MINSEC = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR   = 8'h23;

  // Garbage digits and the wrap value both land on 00; carry is decided by the caller.
  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v >= max) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - BCD seconds/minutes/hours with 1 Hz advance and bus write override
module bcd_time_counter
  import rtc_bus_pkg::*;
#(
  parameter logic [7:0] ADDR_SEC  = DEF_ADDR_SEC,
  parameter logic [7:0] ADDR_MIN  = DEF_ADDR_MIN,
  parameter logic [7:0] ADDR_HOUR = DEF_ADDR_HOUR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       wr_en_i,
  input  logic [7:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] sec_o,
  output logic [7:0] min_o,
  output logic [7:0] hour_o
);

  logic [7:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic       sec_carry, min_carry;

  assign sec_carry = (sec_q == BCD_MAX_MINSEC);
  assign min_carry = (min_q == BCD_MAX_MINSEC);

  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (tick_i) begin
      sec_d = bcd_next(sec_q, BCD_MAX_MINSEC);
      if (sec_carry) begin
        min_d = bcd_next(min_q, BCD_MAX_MINSEC);
        if (min_carry) begin
          hour_d = bcd_next(hour_q, BCD_MAX_HOUR);
        end
      end
    end
    // Bus write overrides only its own register; carries computed above still stand.
    if (wr_en_i) begin
      if (wr_addr_i == ADDR_SEC)  sec_d  = wr_data_i;
      if (wr_addr_i == ADDR_MIN)  min_d  = wr_data_i;
      if (wr_addr_i == ADDR_HOUR) hour_d = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q  <= 8'h00;
      min_q  <= 8'h00;
      hour_q <= 8'h00;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
    end
  end

  assign sec_o  = sec_q;
  assign min_o  = min_q;
  assign hour_o = hour_q;

endmodule

// File: rtl/rtc_bus_responder.sv
// rtl/rtc_bus_responder.sv - RTC-side responder for the multiplexed a_d/cs/wr/rd/AD bus
module rtc_bus_responder
  import rtc_bus_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         REG_COUNT   = 16,
  parameter logic [7:0] ADDR_SEC    = DEF_ADDR_SEC,
  parameter logic [7:0] ADDR_MIN    = DEF_ADDR_MIN,
  parameter logic [7:0] ADDR_HOUR   = DEF_ADDR_HOUR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       a_d,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic       tick_1hz,
  output logic [7:0] addr_latched,
  output logic       wr_done
);

  localparam int         AW        = $clog2(REG_COUNT);
  localparam logic [8:0] REG_LIMIT = 9'(REG_COUNT);
  localparam logic [11:0] BUS_IDLE = {IDLE_CS, IDLE_A_D, IDLE_WR, IDLE_RD, IDLE_AD};

  logic [11:0] sync_q [SYNC_STAGES];
  logic [1:0]  prev_q;
  logic        cs_s, a_d_s, wr_s, rd_s;
  logic [7:0]  ad_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= BUS_IDLE;
      prev_q <= {IDLE_WR, IDLE_RD};
    end else begin
      sync_q[0] <= {cs, a_d, wr, rd, ad_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= {wr_s, rd_s};
    end
  end

  assign {cs_s, a_d_s, wr_s, rd_s, ad_s} = sync_q[SYNC_STAGES-1];

  logic wr_fall, wr_rise, rd_fall, rd_rise;
  assign wr_fall = prev_q[1] & ~wr_s;
  assign wr_rise = ~prev_q[1] & wr_s;
  assign rd_fall = prev_q[0] & ~rd_s;
  assign rd_rise = ~prev_q[0] & rd_s;

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d, ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d, wr_done_q, commit;
  logic       in_range, is_time;
  logic [7:0] rd_data, sec, min, hour;
  logic [7:0] regs_q [REG_COUNT];

  assign in_range = ({1'b0, addr_q} < REG_LIMIT);
  assign is_time  = (addr_q == ADDR_SEC) || (addr_q == ADDR_MIN) || (addr_q == ADDR_HOUR);

  always_comb begin
    rd_data = 8'h00;
    if (in_range) begin
      if (addr_q == ADDR_SEC)       rd_data = sec;
      else if (addr_q == ADDR_MIN)  rd_data = min;
      else if (addr_q == ADDR_HOUR) rd_data = hour;
      else                          rd_data = regs_q[addr_q[AW-1:0]];
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ad_out_d = ad_out_q;
    ad_oe_d  = ad_oe_q;
    commit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cs_s && !a_d_s && wr_fall) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (cs_s) begin
          state_d = ST_IDLE;
        end else if (wr_rise) begin
          addr_d  = ad_s;
          state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        // A strobe falling while the other is already low is a collision and is ignored.
        if (cs_s) begin
          state_d = ST_IDLE;
        end else if (!a_d_s && wr_fall) begin
          state_d = ST_ADDR;
        end else if (a_d_s && wr_fall && rd_s) begin
          state_d = ST_WRITE;
        end else if (a_d_s && rd_fall && wr_s) begin
          state_d  = ST_READ;
          ad_out_d = rd_data;
          ad_oe_d  = 1'b1;
        end
      end
      ST_WRITE: begin
        if (cs_s) begin
          state_d = ST_IDLE;
        end else if (wr_rise) begin
          commit  = in_range;
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (cs_s || rd_rise) begin
          ad_oe_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ad_oe_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= 8'h00;
      ad_out_q  <= 8'h00;
      ad_oe_q   <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ad_out_q  <= ad_out_d;
      ad_oe_q   <= ad_oe_d;
      wr_done_q <= commit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 8'h00;
    end else if (commit && !is_time) begin
      regs_q[addr_q[AW-1:0]] <= ad_s;
    end
  end

  bcd_time_counter #(
    .ADDR_SEC  (ADDR_SEC),
    .ADDR_MIN  (ADDR_MIN),
    .ADDR_HOUR (ADDR_HOUR)
  ) u_time (
    .clk       (clk),
    .rst_n     (rst),
    .tick_i    (tick_1hz),
    .wr_en_i   (commit),
    .wr_addr_i (addr_q),
    .wr_data_i (ad_s),
    .sec_o     (sec),
    .min_o     (min),
    .hour_o    (hour)
  );

  assign ad_out       = ad_out_q;
  assign ad_oe        = ad_oe_q;
  assign addr_latched = addr_q;
  assign wr_done      = wr_done_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb/tb_rtc_bus_responder.sv - randomized self-checking bench for rtc_bus_responder
module tb_rtc_bus_responder;

  logic       clk = 1'b0;
  logic       rst, cs, a_d, wr, rd, tick_1hz;
  logic [7:0] ad_in, ad_out, addr_latched;
  logic       ad_oe, wr_done;

  int checks = 0;
  int errors = 0;
  int wr_done_cnt = 0;
  logic [7:0] mdl [16];

  rtc_bus_responder dut (
    .clk          (clk),
    .rst          (rst),
    .cs           (cs),
    .a_d          (a_d),
    .wr           (wr),
    .rd           (rd),
    .ad_in        (ad_in),
    .ad_out       (ad_out),
    .ad_oe        (ad_oe),
    .tick_1hz     (tick_1hz),
    .addr_latched (addr_latched),
    .wr_done      (wr_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_done) wr_done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    if (b[3:0] > 9 || b[7:4] > 9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Advance one time field; returns 1 when it wrapped from its exact maximum.
  function automatic bit adv(input int idx, input int maxv);
    int v = bcd_val(mdl[idx]);
    if (v < 0 || v > maxv) begin
      mdl[idx] = 8'h00;
      return 1'b0;
    end
    if (v == maxv) begin
      mdl[idx] = 8'h00;
      return 1'b1;
    end
    mdl[idx] = to_bcd(v + 1);
    return 1'b0;
  endfunction

  task automatic mdl_tick();
    if (adv(0, 59)) begin
      if (adv(1, 59)) void'(adv(2, 23));
    end
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    idle(1);
    tick_1hz = 1'b0;
    mdl_tick();
  endtask

  task automatic addr_phase(input logic [7:0] a);
    cs = 1'b0; a_d = 1'b0; ad_in = a;
    idle(4); wr = 1'b0;
    idle(4); wr = 1'b1;
    idle(4);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    int c0 = wr_done_cnt;
    addr_phase(a);
    a_d = 1'b1; ad_in = d;
    idle(2); wr = 1'b0;
    idle(4); wr = 1'b1;
    idle(5);
    chk("addr_latched", 32'(addr_latched), 32'(a));
    chk("wr_done_count", 32'(wr_done_cnt - c0), (a < 8'd16) ? 32'd1 : 32'd0);
    cs = 1'b1; a_d = 1'b0;
    idle(4);
    if (a < 8'd16) mdl[a[3:0]] = d;
  endtask

  task automatic bus_read(input logic [7:0] a, input string tag);
    logic [7:0] exp = (a < 8'd16) ? mdl[a[3:0]] : 8'h00;
    addr_phase(a);
    a_d = 1'b1;
    idle(4); chk("oe_before_rd", 32'(ad_oe), 32'd0);
    rd = 1'b0;
    idle(4); chk("oe_during_rd", 32'(ad_oe), 32'd1);
    chk(tag, 32'(ad_out), 32'(exp));
    rd = 1'b1;
    idle(4); chk("oe_after_rd", 32'(ad_oe), 32'd0);
    cs = 1'b1; a_d = 1'b0;
    idle(4);
  endtask

  initial begin
    logic [7:0] a, d;
    int c0;
    rst = 1'b0; cs = 1'b1; a_d = 1'b0; wr = 1'b1; rd = 1'b1; ad_in = 8'h00; tick_1hz = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;

    idle(3);
    chk("rst_ad_oe", 32'(ad_oe), 32'd0);
    chk("rst_ad_out", 32'(ad_out), 32'd0);
    chk("rst_addr", 32'(addr_latched), 32'd0);
    chk("rst_wr_done", 32'(wr_done), 32'd0);
    rst = 1'b1;
    idle(2);
    bus_read(8'h05, "rst_reg5");

    bus_write(8'h05, 8'hA7);
    bus_read(8'h05, "wr_rd_reg5");

    bus_write(8'h02, 8'h23);
    bus_write(8'h01, 8'h59);
    bus_write(8'h00, 8'h59);
    pulse_tick();
    idle(2);
    bus_read(8'h00, "roll_sec");
    bus_read(8'h01, "roll_min");
    bus_read(8'h02, "roll_hour");

    bus_write(8'h20, 8'h3C);
    bus_read(8'h20, "oor_read");
    for (int i = 0; i < 16; i++) bus_read(8'(i), "oor_regs");

    c0 = wr_done_cnt;
    addr_phase(8'h06);
    a_d = 1'b1; ad_in = 8'h5A;
    idle(2); wr = 1'b0;
    idle(4); cs = 1'b1;
    idle(4); wr = 1'b1; a_d = 1'b0;
    idle(4);
    chk("abort_no_done", 32'(wr_done_cnt - c0), 32'd0);
    bus_read(8'h06, "abort_reg6");

    // Bus write to seconds collides with a tick whose seconds carry still reaches minutes.
    bus_write(8'h00, 8'h59);
    bus_write(8'h01, 8'h12);
    c0 = wr_done_cnt;
    addr_phase(8'h00);
    a_d = 1'b1; ad_in = 8'h10;
    idle(2); wr = 1'b0;
    idle(4); wr = 1'b1;
    idle(2); tick_1hz = 1'b1;
    idle(1); tick_1hz = 1'b0;
    mdl_tick();
    mdl[0] = 8'h10;
    idle(3);
    chk("collide_done", 32'(wr_done_cnt - c0), 32'd1);
    cs = 1'b1; a_d = 1'b0;
    idle(4);
    bus_read(8'h00, "collide_sec");
    bus_read(8'h01, "collide_min");

    bus_write(8'h00, 8'h20);
    addr_phase(8'h00);
    a_d = 1'b1;
    idle(4); rd = 1'b0;
    idle(4); chk("hold_before", 32'(ad_out), 32'h20);
    pulse_tick();
    idle(2); chk("hold_after_tick", 32'(ad_out), 32'h20);
    rd = 1'b1;
    idle(4); cs = 1'b1; a_d = 1'b0;
    idle(4);
    bus_read(8'h00, "sec_after_hold");

    bus_write(8'h00, 8'h4F);
    pulse_tick();
    idle(2);
    bus_read(8'h00, "nonbcd_fix");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 8'($urandom_range(0, 15));
          if (a == 8'h02)      d = to_bcd($urandom_range(0, 23));
          else if (a < 8'h02)  d = to_bcd($urandom_range(0, 59));
          else                 d = 8'($urandom);
          bus_write(a, d);
        end
        1: bus_write(8'($urandom_range(16, 255)), 8'($urandom));
        2: bus_read(8'($urandom_range(0, 20)), "rand_read");
        default: begin
          pulse_tick();
          idle(2);
        end
      endcase
    end

    addr_phase(8'h05);
    a_d = 1'b1; rd = 1'b0;
    idle(4); chk("mid_rst_oe_pre", 32'(ad_oe), 32'd1);
    #2 rst = 1'b0;
    #1 chk("mid_rst_oe_async", 32'(ad_oe), 32'd0);
    rd = 1'b1; cs = 1'b1; a_d = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    idle(2); rst = 1'b1;
    idle(2);
    chk("mid_rst_addr", 32'(addr_latched), 32'd0);
    for (int i = 0; i < 16; i++) bus_read(8'(i), "post_rst_reg");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
